div_sqrt_tagged_queue: RTL and testbench
========================================

# div_sqrt_tagged_queue

Tagged request/response adapter that sits between a client and `divSqrtRecFN_medium`.
- Upstream side: accepts tagged divide/sqrt requests and issues them to the divider when it is ready.
- Downstream side: captures the divider's single-cycle result pulse, which has no backpressure, together with the request's tag and `sqrtOp`, and buffers it in a small FIFO.
- Client side: drains results through a valid/ready handshake.
- Issue is credit-limited, so a result pulse is never dropped.

## Interface
- `expWidth`, 8, exponent width of the recoded format
- `sigWidth`, 24, significand width of the recoded format
- `tagWidth`, 4, client tag width
- `depth`, 2, result FIFO entries; legal range 1..16, power of two not required
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `inReady`  out  1  request accepted this cycle if `inValid`
- `inValid`  in  1  request present
- `inTag`  in  tagWidth  client tag
- `sqrtOp`  in  1  1 = sqrt(a), 0 = a/b
- `a`, `b`  in  expWidth+sigWidth+1  recoded operands
- `roundingMode`  in  3  rounding mode
- `divInValid`  out  1  to divider `inValid`
- `divInReady`  in  1  from divider `inReady`
- `divSqrtOp`, `divA`, `divB`, `divRoundingMode`  out  -  combinational pass-through of request fields
- `divOutValid`  in  1  divider result pulse
- `divOut`  in  expWidth+sigWidth+1  divider result
- `divExceptionFlags`  in  5  divider flags
- `outValid`  out  1  FIFO head valid
- `outReady`  in  1  client consumes head
- `outTag`  out  tagWidth  tag of head entry
- `outSqrtOp`  out  1  `sqrtOp` of head entry
- `out`  out  expWidth+sigWidth+1  result of head entry
- `exceptionFlags`  out  5  flags of head entry

## Operation
- State:
  - `inFlight` (1 bit), `inFlightTag` and `inFlightSqrtOp`.
  - FIFO storage of `depth` entries, each holding {tag, sqrtOp, out, flags}.
  - `rdPtr` and `wrPtr`, each clog2(depth) bits, wrapping from depth-1 to 0.
  - `count`, clog2(depth+1) bits.
- Credit and issue:
  - `inReady = divInReady && (count + inFlight < depth)`. It is purely registered state plus `divInReady`, with no path from `outReady`.
  - `divInValid = inValid && inReady`. Request fields pass through combinationally.
- Accept cycle: `inFlight` <= 1, and `inFlightTag` / `inFlightSqrtOp` <= inputs.
- Completion (`divOutValid && inFlight`):
  - Write {`inFlightTag`, `inFlightSqrtOp`, `divOut`, `divExceptionFlags`} at `wrPtr` and advance `wrPtr`.
  - `inFlight` <= 0, unless an accept happens in the same cycle, which sets it to 1.
- Same-cycle completion and accept is legal, because the divider raises `inReady` during its result cycle. Occupancy is unchanged.
- Pop (`outValid && outReady`): advance `rdPtr`.
- `count` update: push only +1, pop only -1, push and pop together unchanged.
- Full FIFO: credit makes push-when-full impossible. If it happens anyway, the simulation assertion fires and the write is ignored.
- `divOutValid` while `!inFlight`: protocol error. Assertion fires, nothing is enqueued, and the state is unchanged.
- Outputs `outTag`, `outSqrtOp`, `out` and `exceptionFlags` show the entry at `rdPtr`. Their values are don't-care when `outValid` = 0.
- Reset:
  - Clears `inFlight`, `count`, both pointers and all storage to 0.
  - Reset mid-operation discards the in-flight request and all buffered results. The top level drives the divider's `nReset` = !`reset`, so both blocks reset together.

## Timing
- Reset values:
  - `outValid` = 0, and all `out*` data = 0.
  - `divInValid` = 0 while `inValid` = 0.
  - `inReady` equals `divInReady`.
- Enqueue to `outValid`: 1 cycle. The entry is written at the edge ending the `divOutValid` cycle. There is no bypass.
- End-to-end latency = divider latency + 1:
  - Special-case operands: accept at cycle 0, `divOutValid` at cycle 1, `outValid` at cycle 2.
- Throughput: one operation per divider latency, as long as `outReady` keeps the FIFO below `depth`.
- With `depth` = 1 and the head not popped, `inReady` stays 0 until the pop cycle. The next accept can happen 1 cycle after the pop.

## Structure
- The shared include holds:
  - the flag bit positions {invalid, infinite, overflow, underflow, inexact}, so `exceptionFlags` 5'b01000 = infinite;
  - a `clog2` local function.
- One sub-module, `div_sqrt_result_fifo`: parameterised width/depth synchronous FIFO with push/pop/count and registered head output. The adapter holds only the in-flight register and the credit logic.

## Test plan
- 4.0 (0x081000000) / 2.0 (0x080800000), tag 3 -> `outValid` with `outTag` 3, `out` 0x080800000, flags 0.
- sqrt 4.0, tag 5 -> `out` 0x080800000, `outSqrtOp` 1, flags 0.
- 1.0 (0x080000000) / +0 (0x000000000) -> `divOutValid` exactly 1 cycle after accept, `outValid` the next cycle, `out` +inf 0x0C0000000, flags 5'b01000.
- `depth` = 2, `outReady` held 0, requests with tags 1, 2, 3:
  - tags 1 and 2 complete;
  - `inReady` stays 0 for tag 3 until the first pop;
  - pops return tags 1, 2, 3 in order, and no result is lost.
- Back-to-back special-case requests:
  - a new request is accepted in the same cycle as `divOutValid`;
  - with `outReady` = 1, the client sees consecutive tags in consecutive cycles once the pipeline is primed.
- Assert `reset` for one cycle while a normal divide is in flight and 1 entry is buffered -> next cycle `outValid` = 0, `count` = 0, `inReady` = `divInReady`, and the stale result is never emitted.

Source files
------------

// File: rtl/div_sqrt_tagged_queue_pkg.sv
// rtl/div_sqrt_tagged_queue_pkg.sv - shared flag layout and helpers for the div/sqrt tagged queue
package div_sqrt_tagged_queue_pkg;

  localparam int FLAG_W         = 5;
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_INFINITE  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef struct packed {
    logic invalid;
    logic infinite;
    logic overflow;
    logic underflow;
    logic inexact;
  } exc_flags_t;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/div_sqrt_result_fifo.sv
// rtl/div_sqrt_result_fifo.sv - synchronous result FIFO with occupancy count
// Head data is read straight from the storage registers; there is no write-to-read bypass.
module div_sqrt_result_fifo
  import div_sqrt_tagged_queue_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [width-1:0]          push_data,
  input  logic                      pop,
  output logic                      valid,
  output logic [width-1:0]          head,
  output logic [clog2(depth+1)-1:0] count
);

  localparam int PTR_W = (clog2(depth) < 1) ? 1 : clog2(depth);
  localparam int CNT_W = clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             push_en;
  logic             pop_en;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(depth - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(depth));
  assign push_en = push && !full;
  assign pop_en  = pop && valid;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop_en) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  overflow_a: assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/div_sqrt_tagged_queue.sv
// rtl/div_sqrt_tagged_queue.sv - tagged request/response adapter around a div/sqrt unit
// Issue is credit-limited so the unbackpressured result pulse always finds a free FIFO slot.
module div_sqrt_tagged_queue
  import div_sqrt_tagged_queue_pkg::*;
#(
  parameter int expWidth = 8,
  parameter int sigWidth = 24,
  parameter int tagWidth = 4,
  parameter int depth    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       inReady,
  input  logic                       inValid,
  input  logic [tagWidth-1:0]        inTag,
  input  logic                       sqrtOp,
  input  logic [expWidth+sigWidth:0] a,
  input  logic [expWidth+sigWidth:0] b,
  input  logic [2:0]                 roundingMode,
  output logic                       divInValid,
  input  logic                       divInReady,
  output logic                       divSqrtOp,
  output logic [expWidth+sigWidth:0] divA,
  output logic [expWidth+sigWidth:0] divB,
  output logic [2:0]                 divRoundingMode,
  input  logic                       divOutValid,
  input  logic [expWidth+sigWidth:0] divOut,
  input  logic [FLAG_W-1:0]          divExceptionFlags,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [tagWidth-1:0]        outTag,
  output logic                       outSqrtOp,
  output logic [expWidth+sigWidth:0] out,
  output logic [FLAG_W-1:0]          exceptionFlags
);

  localparam int REC_W   = expWidth + sigWidth + 1;
  localparam int ENTRY_W = tagWidth + 1 + REC_W + FLAG_W;
  localparam int CNT_W   = clog2(depth + 1);

  logic                in_flight;
  logic [tagWidth-1:0] in_flight_tag;
  logic                in_flight_sqrt;
  logic                accept;
  logic                complete;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;

  // Credit counts buffered plus in-flight results; outReady deliberately not involved.
  assign inReady    = divInReady && ((int'(fifo_count) + int'(in_flight)) < depth);
  assign accept     = inValid && inReady;
  assign divInValid = accept;
  assign complete   = divOutValid && in_flight;

  assign divSqrtOp       = sqrtOp;
  assign divA            = a;
  assign divB            = b;
  assign divRoundingMode = roundingMode;

  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight      <= 1'b0;
      in_flight_tag  <= '0;
      in_flight_sqrt <= 1'b0;
    end else if (accept) begin
      in_flight      <= 1'b1;
      in_flight_tag  <= inTag;
      in_flight_sqrt <= sqrtOp;
    end else if (complete) begin
      in_flight      <= 1'b0;
    end
  end

  assign push_entry = {in_flight_tag, in_flight_sqrt, divOut, divExceptionFlags};
  assign {outTag, outSqrtOp, out, exceptionFlags} = head_entry;

  div_sqrt_result_fifo #(
    .width (ENTRY_W),
    .depth (depth)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (complete),
    .push_data (push_entry),
    .pop       (outReady),
    .valid     (outValid),
    .head      (head_entry),
    .count     (fifo_count)
  );

  protocol_a: assert property (@(posedge clock) disable iff (reset) divOutValid |-> in_flight);

endmodule

// File: tb/tb_div_sqrt_tagged_queue.sv
// tb/tb_div_sqrt_tagged_queue.sv - directed bench for div_sqrt_tagged_queue with a scripted divider
module tb_div_sqrt_tagged_queue;
  import div_sqrt_tagged_queue_pkg::*;

  localparam logic [32:0] F4   = 33'h081000000;
  localparam logic [32:0] F2   = 33'h080800000;
  localparam logic [32:0] F1   = 33'h080000000;
  localparam logic [32:0] PZ   = 33'h000000000;
  localparam logic [32:0] PINF = 33'h0C0000000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inReady;
  logic        inValid = 1'b0;
  logic [3:0]  inTag = '0;
  logic        sqrtOp = 1'b0;
  logic [32:0] a = '0;
  logic [32:0] b = '0;
  logic [2:0]  roundingMode = '0;
  logic        divInValid;
  logic        divInReady = 1'b1;
  logic        divSqrtOp;
  logic [32:0] divA;
  logic [32:0] divB;
  logic [2:0]  divRoundingMode;
  logic        divOutValid = 1'b0;
  logic [32:0] divOut = '0;
  logic [4:0]  divExceptionFlags = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [3:0]  outTag;
  logic        outSqrtOp;
  logic [32:0] out;
  logic [4:0]  exceptionFlags;

  int n_cmp = 0;
  int n_bad = 0;

  int         next_tag;
  int         exp_tag;
  int         last_out;
  int         stale_hits;
  logic       pend;
  logic [3:0] pend_tag;
  logic       took;
  logic       saw_overlap;
  logic       saw_b2b;

  always #5 clock = ~clock;

  div_sqrt_tagged_queue dut (
    .clock             (clock),
    .reset             (reset),
    .inReady           (inReady),
    .inValid           (inValid),
    .inTag             (inTag),
    .sqrtOp            (sqrtOp),
    .a                 (a),
    .b                 (b),
    .roundingMode      (roundingMode),
    .divInValid        (divInValid),
    .divInReady        (divInReady),
    .divSqrtOp         (divSqrtOp),
    .divA              (divA),
    .divB              (divB),
    .divRoundingMode   (divRoundingMode),
    .divOutValid       (divOutValid),
    .divOut            (divOut),
    .divExceptionFlags (divExceptionFlags),
    .outValid          (outValid),
    .outReady          (outReady),
    .outTag            (outTag),
    .outSqrtOp         (outSqrtOp),
    .out               (out),
    .exceptionFlags    (exceptionFlags)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] tag, input logic sq, input logic [32:0] ia, input logic [32:0] ib);
    int n;
    n       = 0;
    inValid = 1'b1;
    inTag   = tag;
    sqrtOp  = sq;
    a       = ia;
    b       = ib;
    #1;
    while (!inReady && n < 20) begin
      tick();
      n++;
    end
    check_eq("issue_ready", 64'(inReady), 64'd1);
    tick();
    inValid = 1'b0;
  endtask

  task automatic complete(input logic [32:0] res, input logic [4:0] flags);
    divOutValid       = 1'b1;
    divOut            = res;
    divExceptionFlags = flags;
    tick();
    divOutValid       = 1'b0;
    #1;
  endtask

  task automatic pop_one();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    #1;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_outValid", 64'(outValid), 64'd0);
    check_eq("rst_outTag", 64'(outTag), 64'd0);
    check_eq("rst_out", 64'(out), 64'd0);
    check_eq("rst_flags", 64'(exceptionFlags), 64'd0);
    check_eq("rst_outSqrt", 64'(outSqrtOp), 64'd0);
    check_eq("rst_divInValid", 64'(divInValid), 64'd0);
    check_eq("rst_inReady_hi", 64'(inReady), 64'd1);
    divInReady = 1'b0;
    #1;
    check_eq("rst_inReady_lo", 64'(inReady), 64'd0);
    divInReady = 1'b1;

    // 4.0 / 2.0, tag 3, multi-cycle divider
    inValid = 1'b1; inTag = 4'd3; sqrtOp = 1'b0; a = F4; b = F2; roundingMode = 3'd2;
    #1;
    check_eq("pass_divInValid", 64'(divInValid), 64'd1);
    check_eq("pass_divA", 64'(divA), 64'(F4));
    check_eq("pass_divB", 64'(divB), 64'(F2));
    check_eq("pass_sqrt", 64'(divSqrtOp), 64'd0);
    check_eq("pass_rm", 64'(divRoundingMode), 64'd2);
    issue(4'd3, 1'b0, F4, F2);
    divInReady = 1'b0;
    tick();
    tick();
    divOutValid = 1'b1; divOut = F2; divExceptionFlags = 5'd0;
    #1;
    check_eq("div_no_bypass", 64'(outValid), 64'd0);
    tick();
    divOutValid = 1'b0;
    divInReady  = 1'b1;
    #1;
    check_eq("div_valid", 64'(outValid), 64'd1);
    check_eq("div_tag", 64'(outTag), 64'd3);
    check_eq("div_out", 64'(out), 64'(F2));
    check_eq("div_flags", 64'(exceptionFlags), 64'd0);
    check_eq("div_sqrt", 64'(outSqrtOp), 64'd0);
    pop_one();
    check_eq("div_popped", 64'(outValid), 64'd0);

    // sqrt(4.0), tag 5
    issue(4'd5, 1'b1, F4, PZ);
    tick();
    complete(F2, 5'd0);
    check_eq("sqrt_tag", 64'(outTag), 64'd5);
    check_eq("sqrt_out", 64'(out), 64'(F2));
    check_eq("sqrt_op", 64'(outSqrtOp), 64'd1);
    check_eq("sqrt_flags", 64'(exceptionFlags), 64'd0);
    pop_one();

    // 1.0 / +0: result the cycle after accept, outValid the cycle after that
    issue(4'd7, 1'b0, F1, PZ);
    divOutValid = 1'b1; divOut = PINF; divExceptionFlags = 5'(1 << FLAG_INFINITE);
    #1;
    check_eq("dz_no_bypass", 64'(outValid), 64'd0);
    tick();
    divOutValid = 1'b0;
    #1;
    check_eq("dz_valid", 64'(outValid), 64'd1);
    check_eq("dz_out", 64'(out), 64'h0C0000000);
    check_eq("dz_flags", 64'(exceptionFlags), 64'b01000);
    check_eq("dz_tag", 64'(outTag), 64'd7);
    pop_one();

    // credit limit with depth 2 and outReady held low
    issue(4'd1, 1'b0, F4, F2);
    complete(33'h101, 5'd0);
    issue(4'd2, 1'b0, F4, F2);
    complete(33'h102, 5'd1);
    inValid = 1'b1; inTag = 4'd3;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("credit_block", 64'(inReady), 64'd0);
      check_eq("credit_no_issue", 64'(divInValid), 64'd0);
      tick();
    end
    outReady = 1'b1;
    #1;
    check_eq("credit_no_ready_path", 64'(inReady), 64'd0);
    check_eq("fifo_head1_tag", 64'(outTag), 64'd1);
    check_eq("fifo_head1_out", 64'(out), 64'h101);
    tick();
    outReady = 1'b0;
    #1;
    check_eq("credit_return", 64'(inReady), 64'd1);
    tick();
    inValid = 1'b0;
    complete(33'h103, 5'd2);
    for (int k = 2; k <= 3; k++) begin
      check_eq("fifo_valid", 64'(outValid), 64'd1);
      check_eq("fifo_tag", 64'(outTag), 64'(k));
      check_eq("fifo_out", 64'(out), 64'h100 + 64'(k));
      check_eq("fifo_flags", 64'(exceptionFlags), 64'(k - 1));
      pop_one();
    end
    check_eq("fifo_empty", 64'(outValid), 64'd0);

    // back-to-back special-case requests with a one-cycle divider
    outReady    = 1'b1;
    divInReady  = 1'b1;
    next_tag    = 6;
    exp_tag     = 6;
    last_out    = -10;
    pend        = 1'b0;
    pend_tag    = '0;
    saw_overlap = 1'b0;
    saw_b2b     = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      inValid           = (next_tag <= 9);
      inTag             = 4'(next_tag);
      sqrtOp            = 1'b0;
      a                 = F1;
      b                 = PZ;
      divOutValid       = pend;
      divOut            = 33'h100 + 33'(pend_tag);
      divExceptionFlags = 5'd0;
      #1;
      if (outValid) begin
        check_eq("b2b_tag", 64'(outTag), 64'(exp_tag));
        check_eq("b2b_out", 64'(out), 64'h100 + 64'(exp_tag));
        if (last_out == cyc - 1) saw_b2b = 1'b1;
        last_out = cyc;
        exp_tag++;
      end
      took = inValid && inReady;
      if (took && divOutValid) saw_overlap = 1'b1;
      tick();
      pend = took;
      if (took) begin
        pend_tag = inTag;
        next_tag++;
      end
    end
    inValid     = 1'b0;
    divOutValid = 1'b0;
    outReady    = 1'b0;
    check_eq("b2b_all_seen", 64'(exp_tag), 64'd10);
    check_eq("b2b_overlap", 64'(saw_overlap), 64'd1);
    check_eq("b2b_consecutive", 64'(saw_b2b), 64'd1);

    // reset while one result is buffered and another is in flight
    issue(4'hA, 1'b0, F4, F2);
    complete(33'h1AA, 5'd1);
    issue(4'hB, 1'b0, F4, F2);
    divInReady = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_outValid", 64'(outValid), 64'd0);
    check_eq("mid_rst_count", 64'(dut.u_fifo.count), 64'd0);
    check_eq("mid_rst_inflight", 64'(dut.in_flight), 64'd0);
    check_eq("mid_rst_inReady_lo", 64'(inReady), 64'd0);
    divInReady = 1'b1;
    #1;
    check_eq("mid_rst_inReady_hi", 64'(inReady), 64'd1);
    stale_hits = 0;
    for (int i = 0; i < 6; i++) begin
      if (outValid) stale_hits++;
      tick();
    end
    check_eq("mid_rst_no_stale", 64'(stale_hits), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
